// File: rtl/prbs16_pkg.sv
// Shared definitions for the PRBS16 checker: the XNOR LFSR step rule
// (taps 16/15/13/4), the lockup word and the checker state encoding.
package prbs16_pkg;

  // All-ones maps onto itself under the XNOR rule, so it can never be a
  // meaningful sequence word.
  localparam logic [15:0] LFSR_LOCKUP = 16'hFFFF;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // One step of the pattern source: shift left, feed back the XNOR of taps.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] q);
    return {q[14:0], ~(q[15] ^ q[14] ^ q[12] ^ q[3])};
  endfunction

endpackage

// File: rtl/prbs16_checker_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Clear beats increment; increments stop once the counter is all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/prbs16_checker.sv
// PRBS16 sequence checker. Self-synchronises to the incoming stream
// (HUNT -> SYNC -> LOCKED), then predicts each word from a free-running
// internal copy of the sequence so a single corrupted word costs exactly
// one error. Errors while locked are pulsed and counted.
//
// Handshake: valid_in qualifies data_in for one cycle; there is no
// backpressure, every cycle with valid_in=1 consumes exactly one word and
// cycles with valid_in=0 leave all sequence state untouched.
module prbs16_checker
  import prbs16_pkg::*;
#(
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 4,
  parameter int ERR_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [15:0]      data_in,
  input  logic             clear_errs,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output state_t           state_dbg
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int UW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [MW-1:0] LOCK_TGT   = MW'(LOCK_COUNT);
  localparam logic [UW-1:0] UNLOCK_TGT = UW'(UNLOCK_COUNT);

  state_t        state, state_nxt;
  logic [15:0]   last_word, last_word_nxt;
  logic [15:0]   exp_word, exp_nxt;
  logic [MW-1:0] match_cnt, match_cnt_nxt;
  logic [UW-1:0] miss_cnt, miss_cnt_nxt;
  logic          err_hit;

  logic [15:0]   pred_sync;
  logic [MW-1:0] match_inc;
  logic [UW-1:0] miss_inc;

  assign pred_sync = lfsr16_next(last_word);
  assign match_inc = match_cnt + MW'(1);
  assign miss_inc  = miss_cnt + UW'(1);
  assign state_dbg = state;

  // Next-state and datapath decisions; nothing moves without valid_in.
  always_comb begin
    state_nxt     = state;
    last_word_nxt = last_word;
    exp_nxt       = exp_word;
    match_cnt_nxt = match_cnt;
    miss_cnt_nxt  = miss_cnt;
    err_hit       = 1'b0;
    if (valid_in) begin
      case (state)
        HUNT: begin
          last_word_nxt = data_in;
          match_cnt_nxt = '0;
          state_nxt     = SYNC;
        end
        SYNC: begin
          last_word_nxt = data_in;
          if ((data_in == pred_sync) && (data_in != LFSR_LOCKUP)) begin
            match_cnt_nxt = match_inc;
            if (match_inc == LOCK_TGT) begin
              state_nxt    = LOCKED;
              exp_nxt      = lfsr16_next(data_in);
              miss_cnt_nxt = '0;
            end
          end else begin
            match_cnt_nxt = '0;
          end
        end
        LOCKED: begin
          // Prediction advances whether or not the word was good.
          exp_nxt = lfsr16_next(exp_word);
          if (data_in != exp_word) begin
            err_hit      = 1'b1;
            miss_cnt_nxt = miss_inc;
            if (miss_inc == UNLOCK_TGT) begin
              state_nxt     = HUNT;
              miss_cnt_nxt  = '0;
              match_cnt_nxt = '0;
            end
          end else begin
            miss_cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt = HUNT;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      last_word <= '0;
      exp_word  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_word <= last_word_nxt;
      exp_word  <= exp_nxt;
      match_cnt <= match_cnt_nxt;
      miss_cnt  <= miss_cnt_nxt;
      locked    <= (state_nxt == LOCKED);
      err_pulse <= err_hit;
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_count (
    .clk  (clk),
    .reset(reset),
    .inc  (err_hit),
    .clr  (clear_errs),
    .count(err_count)
  );

endmodule

// File: tb/tb_prbs16_checker.sv
// Bench for prbs16_checker: two instances (16-bit and 4-bit error counters)
// share one stimulus stream; a word-history reference model predicts the
// outputs every cycle, plus directed literal checks at key points.
module tb_prbs16_checker;
  import prbs16_pkg::*;

  localparam int LC = 8;
  localparam int UC = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic        clear_errs = 1'b0;
  logic [15:0] data_in = 16'h0000;

  logic        locked, err_pulse, locked4, err_pulse4;
  logic [15:0] err_count;
  logic [3:0]  err_count4;
  state_t      st, st4;

  always #5 clk = ~clk;

  prbs16_checker #(.LOCK_COUNT(LC), .UNLOCK_COUNT(UC), .ERR_W(16)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .clear_errs(clear_errs), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .state_dbg(st)
  );

  prbs16_checker #(.LOCK_COUNT(LC), .UNLOCK_COUNT(UC), .ERR_W(4)) dut4 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .clear_errs(clear_errs), .locked(locked4), .err_pulse(err_pulse4),
    .err_count(err_count4), .state_dbg(st4)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
  endtask

  // Sequence rule written arithmetically: double, drop bit 16, add feedback.
  function automatic logic [15:0] nxt(input logic [15:0] q);
    int v;
    int fb;
    v  = int'(q);
    fb = 1 - (((v >> 15) + (v >> 14) + (v >> 12) + (v >> 3)) & 1);
    return 16'(((v * 2) % 65536) + fb);
  endfunction

  // ---------------- reference model ----------------
  bit          m_locked;
  bit          m_pulse;
  int          m_cnt16, m_cnt4;
  logic [15:0] m_exp;
  logic [15:0] hist[$];
  int          miss_run;
  logic [21:0] exp_q[$];

  task automatic model_reset();
    m_locked = 0; m_pulse = 0; m_cnt16 = 0; m_cnt4 = 0;
    m_exp = 16'h0; hist.delete(); miss_run = 0;
  endtask

  // Unlocked: lock once the last LC+1 words since hunting began form a
  // chain of LC correct links with no lockup word among the successors.
  // Locked: compare to a free-running prediction; UC misses in a row unlock.
  task automatic model_step(input bit v, input logic [15:0] d, input bit c);
    bit ok;
    m_pulse = 0;
    if (v) begin
      if (!m_locked) begin
        hist.push_back(d);
        if (hist.size() > LC + 1) void'(hist.pop_front());
        if (hist.size() == LC + 1) begin
          ok = 1;
          for (int k = 1; k <= LC; k++)
            if (hist[k] != nxt(hist[k-1]) || hist[k] == 16'hFFFF) ok = 0;
          if (ok) begin
            m_locked = 1; m_exp = nxt(d); miss_run = 0; hist.delete();
          end
        end
      end else begin
        if (d != m_exp) begin
          m_pulse = 1;
          if (m_cnt16 < 65535) m_cnt16++;
          if (m_cnt4 < 15) m_cnt4++;
          miss_run++;
          if (miss_run == UC) begin
            m_locked = 0; miss_run = 0;
          end
        end else begin
          miss_run = 0;
        end
        m_exp = nxt(m_exp);
      end
    end
    if (c) begin
      m_cnt16 = 0; m_cnt4 = 0;
    end
  endtask

  // Compare process: update the model at each edge, check 1 time unit later.
  always @(posedge clk) begin : compare_proc
    logic [21:0] e;
    if (reset) model_reset();
    else model_step(valid_in, data_in, clear_errs);
    exp_q.push_back({m_locked, m_pulse, 16'(m_cnt16), 4'(m_cnt4)});
    #1;
    e = exp_q.pop_front();
    chk("locked", {31'd0, locked}, {31'd0, e[21]});
    chk("err_pulse", {31'd0, err_pulse}, {31'd0, e[20]});
    chk("err_count", {16'd0, err_count}, {16'd0, e[19:4]});
    chk("locked4", {31'd0, locked4}, {31'd0, e[21]});
    chk("err_pulse4", {31'd0, err_pulse4}, {31'd0, e[20]});
    chk("err_count4", {28'd0, err_count4}, {28'd0, e[3:0]});
  end

  // ---------------- driver tasks ----------------
  logic [15:0] cur;

  task automatic drive(input bit v, input logic [15:0] d, input bit c);
    @(negedge clk);
    valid_in = v; data_in = d; clear_errs = c;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic send_good();
    drive(1'b1, cur, 1'b0);
    cur = nxt(cur);
  endtask

  task automatic send_bad(input bit c);
    logic [15:0] mask;
    mask = 16'($urandom_range(1, 16'hFFFF));
    drive(1'b1, cur ^ mask, c);
    cur = nxt(cur);
  endtask

  task automatic idle();
    drive(1'b0, 16'($urandom), 1'b0);
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) idle();
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    chk("rst_err_count", {16'd0, err_count}, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Pin the model's sequence rule to known values.
    chk("nxt_0000", {16'd0, nxt(16'h0000)}, 32'h0001);
    chk("nxt_0007", {16'd0, nxt(16'h0007)}, 32'h000F);
    chk("nxt_00F0", {16'd0, nxt(16'h00F0)}, 32'h01E1);
    chk("nxt_01E1", {16'd0, nxt(16'h01E1)}, 32'h03C3);
    chk("nxt_FFFF", {16'd0, nxt(16'hFFFF)}, 32'hFFFF);

    // Clean lock from 0000: locked after the ninth word.
    cur = 16'h0000;
    repeat (LC) send_good();
    settle();
    chk("lock_not_early", {31'd0, locked}, 32'd0);
    send_good();
    settle();
    chk("lock_on_9th", {31'd0, locked}, 32'd1);
    chk("lock_no_errs", {16'd0, err_count}, 32'd0);

    // Single error: 01E0 instead of 01E1, then 03C3 must match.
    chk("expect_01E1", {16'd0, cur}, 32'h01E1);
    drive(1'b1, 16'h01E0, 1'b0); cur = nxt(cur);
    settle();
    chk("single_pulse", {31'd0, err_pulse}, 32'd1);
    chk("single_count", {16'd0, err_count}, 32'd1);
    chk("single_locked", {31'd0, locked}, 32'd1);
    send_good();
    settle();
    chk("after_single_pulse", {31'd0, err_pulse}, 32'd0);
    chk("after_single_count", {16'd0, err_count}, 32'd1);

    repeat (20) begin gap(); send_good(); end

    // Clear on the same cycle as an error: clear wins, pulse still fires.
    send_bad(1'b1);
    settle();
    chk("clr_wins_count", {16'd0, err_count}, 32'd0);
    chk("clr_keeps_pulse", {31'd0, err_pulse}, 32'd1);
    send_good();

    // Loss of lock after four consecutive bad words.
    repeat (UC - 1) send_bad(1'b0);
    settle();
    chk("still_locked_3", {31'd0, locked}, 32'd1);
    send_bad(1'b0);
    settle();
    chk("unlock_4", {31'd0, locked}, 32'd0);
    chk("unlock_count", {16'd0, err_count}, 32'd4);

    // Relock from a fresh seed with gaps; no errors counted while resyncing.
    cur = 16'($urandom_range(0, 16'hFFFE));
    repeat (LC) begin gap(); send_good(); end
    settle();
    chk("relock_not_early", {31'd0, locked}, 32'd0);
    gap(); send_good();
    settle();
    chk("relock_9th", {31'd0, locked}, 32'd1);
    chk("relock_count", {16'd0, err_count}, 32'd4);

    // Random mixed traffic: gaps, corruptions, occasional clears.
    repeat (400) begin
      r = $urandom_range(0, 99);
      if (r < 25) idle();
      else if (r < 33) send_bad($urandom_range(0, 9) == 0);
      else begin
        drive(1'b1, cur, $urandom_range(0, 19) == 0);
        cur = nxt(cur);
      end
    end

    // Lockup word never locks.
    pulse_reset();
    repeat (20) drive(1'b1, 16'hFFFF, 1'b0);
    settle();
    chk("lockup_unlocked", {31'd0, locked}, 32'd0);
    chk("lockup_no_errs", {16'd0, err_count}, 32'd0);

    // Saturation: 20 errors across five lock/unlock rounds.
    pulse_reset();
    cur = 16'($urandom_range(0, 16'hFFFE));
    repeat (5) begin
      repeat (LC + 1) send_good();
      repeat (UC) send_bad(1'b0);
    end
    settle();
    chk("sat_count4", {28'd0, err_count4}, 32'd15);
    chk("sat_count16", {16'd0, err_count}, 32'd20);

    // Asynchronous reset mid-cycle while an error pulse is showing.
    repeat (LC + 1) send_good();
    send_bad(1'b0);
    settle();
    chk("pre_reset_pulse", {31'd0, err_pulse}, 32'd1);
    @(negedge clk); #2; reset = 1'b1;
    #1;
    chk("async_locked", {31'd0, locked}, 32'd0);
    chk("async_err_pulse", {31'd0, err_pulse}, 32'd0);
    chk("async_err_count", {16'd0, err_count}, 32'd0);
    chk("async_err_count4", {28'd0, err_count4}, 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (LC) send_good();
    settle();
    chk("post_reset_needs_full_sync", {31'd0, locked}, 32'd0);
    send_good();
    settle();
    chk("post_reset_relock", {31'd0, locked}, 32'd1);

    idle();
    repeat (3) @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
